// File: rtl/mult_share_arb_pkg.sv
// Shared types and widths for the Calc_G multiplier-sharing arbiter.
// Optional build macro MULT_SHARE_ARB_FIXED_PRIO_EN is consumed by rr_grant and mult_share_arb.
package mult_share_pkg;
   localparam int A_W      = 20;
   localparam int B_W      = 32;
   localparam int FRAC_W   = 12;
   localparam int RES_W    = 12;
   // Wide enough for the largest supported requester count (8)
   localparam int TAG_ID_W = 3;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;
endpackage

// File: rtl/mult_share_arb_if.sv
// Requester-facing bus of mult_share_arb: request handshake plus broadcast response.
// Requesters use the master modport, the arbiter uses the slave modport.
interface mult_share_arb_if
   import mult_share_pkg::*;
#(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]            req_valid;
   logic [N_REQ-1:0]            req_ready;
   logic [N_REQ-1:0][A_W-1:0]   req_a;
   logic [N_REQ-1:0][B_W-1:0]   req_b;
   logic [N_REQ-1:0]            rsp_valid;
   logic [RES_W-1:0]            rsp_data;

   modport master (output req_valid, req_a, req_b,
                   input  req_ready, rsp_valid, rsp_data);
   modport slave  (input  req_valid, req_a, req_b,
                   output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/mult_share_arb_rr_grant.sv
// rr_grant: one-hot selector, rotating priority starting after the last winner.
// With MULT_SHARE_ARB_FIXED_PRIO_EN defined it becomes lowest-index-wins with no pointer.
module rr_grant #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o
`ifndef MULT_SHARE_ARB_FIXED_PRIO_EN
   ,
   input  logic             clk,
   input  logic             rst_n
`endif
);

`ifdef MULT_SHARE_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (req_i[k]) begin
            gnt_o    = '0;
            gnt_o[k] = 1'b1;
            idx_o    = IDX_W'(k);
         end
      end
   end
`else
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W:0]   cand;

   // Scan farthest-first so the candidate nearest ptr+1 is the last to overwrite
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
         if (req_i[cand[IDX_W-1:0]]) begin
            gnt_o                    = '0;
            gnt_o[cand[IDX_W-1:0]]   = 1'b1;
            idx_o                    = cand[IDX_W-1:0];
         end
      end
   end

   assign ptr_d = (|gnt_o) ? idx_o : ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= IDX_W'(N-1);
      else        ptr_q <= ptr_d;
   end
`endif

endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one pipelined 20x32 (20.12) multiplier among N_REQ requesters.
// Define MULT_SHARE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mult_share_arb
   import mult_share_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MULT_LAT = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   mult_share_arb_if.slave              bus,
   output logic [A_W-1:0]               mul_in1,
   output logic [B_W-1:0]               mul_in2,
   input  logic [RES_W-1:0]             mul_out,
   output logic                         busy,
   output logic [$clog2(MULT_LAT+3)-1:0] inflight
);
   localparam int ID_W = $clog2(N_REQ);
   localparam int IF_W = $clog2(MULT_LAT+3);

   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   gnt_idx;
   logic              hs;
   logic [A_W-1:0]    mul_in1_q;
   logic [B_W-1:0]    mul_in2_q;
   // Stage 0 aligns with the operand registers, stage MULT_LAT with mul_out
   tag_t [MULT_LAT:0] tag_q;
   logic [N_REQ-1:0]  rsp_valid_q;
   logic [RES_W-1:0]  rsp_data_q;
   logic [IF_W-1:0]   inflight_q, inflight_d;

   rr_grant #(.N(N_REQ), .IDX_W(ID_W)) u_grant (
      .req_i (bus.req_valid),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
`ifndef MULT_SHARE_ARB_FIXED_PRIO_EN
      ,
      .clk   (clk),
      .rst_n (rst_n)
`endif
   );

   assign hs            = |gnt;
   assign bus.req_ready = gnt;

   always_comb begin
      inflight_d = inflight_q;
      case ({hs, |rsp_valid_q})
         2'b10:   inflight_d = inflight_q + IF_W'(1);
         2'b01:   inflight_d = inflight_q - IF_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_in1_q   <= '0;
         mul_in2_q   <= '0;
         tag_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         inflight_q  <= '0;
      end else begin
         if (hs) begin
            mul_in1_q <= bus.req_a[gnt_idx];
            mul_in2_q <= bus.req_b[gnt_idx];
         end
         tag_q[0] <= '{valid: hs, id: TAG_ID_W'(gnt_idx)};
         for (int k = 1; k <= MULT_LAT; k++) tag_q[k] <= tag_q[k-1];
         if (tag_q[MULT_LAT].valid) begin
            rsp_valid_q <= N_REQ'(1) << tag_q[MULT_LAT].id;
            rsp_data_q  <= mul_out;
         end else begin
            rsp_valid_q <= '0;
         end
         inflight_q <= inflight_d;
      end
   end

   assign mul_in1       = mul_in1_q;
   assign mul_in2       = mul_in2_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign inflight      = inflight_q;
   assign busy          = (inflight_q != '0);

endmodule
